// File: rtl/rob_pkg.sv
// Shared types and default sizing for the reorder buffer.
package rob_pkg;

    localparam int DEPTH    = 8;
    localparam int WB_PORTS = 2;
    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;

    // One reorder-buffer slot. dst_reg is the destination register address.
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [REG_AW-1:0] dst_reg;
        logic [DATA_W-1:0] val;
        logic              w;
        logic              load;
        logic              store;
        logic              jump;
        logic              busy;
        logic              done;
    } rob_entry_t;

endpackage

// File: rtl/rob_fwd_search.sv
// Youngest-match register lookup across the live reorder-buffer window.
// Only instantiated when ROB_FWD_EN is defined.
module rob_fwd_search import rob_pkg::*; #(
    parameter  int ENTRIES = DEPTH,
    localparam int IW      = $clog2(ENTRIES)
) (
    input  rob_entry_t        ent_i [ENTRIES],
    input  logic [IW-1:0]     head_i,
    input  logic [REG_AW-1:0] q_reg_i,
    output logic              q_hit_o,
    output logic              q_ready_o,
    output logic [DATA_W-1:0] q_val_o
);

    logic [IW-1:0] idx;
    logic          fwd_unused;

    // Walk from oldest (head) to youngest; a later match overrides, so the youngest wins.
    always_comb begin
        q_hit_o    = 1'b0;
        q_ready_o  = 1'b0;
        q_val_o    = '0;
        idx        = '0;
        fwd_unused = 1'b0;
        for (int k = 0; k < ENTRIES; k++) begin
            idx = head_i + IW'(k);
            // Fields the lookup never looks at.
            fwd_unused = fwd_unused ^ (^{ent_i[idx].pc, ent_i[idx].load,
                                         ent_i[idx].store, ent_i[idx].jump});
            if (ent_i[idx].busy && ent_i[idx].w && (ent_i[idx].dst_reg == q_reg_i)) begin
                q_hit_o   = 1'b1;
                q_ready_o = ent_i[idx].done;
                q_val_o   = ent_i[idx].done ? ent_i[idx].val : '0;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_mp.sv
// Multi-port reorder buffer: in-order allocate, out-of-order writeback,
// registered in-order commit, flush on a committed jump.
// Optional register forwarding lookup enabled by defining ROB_FWD_EN.
module reorder_buffer_mp #(
    parameter  int DEPTH    = rob_pkg::DEPTH,
    parameter  int WB_PORTS = rob_pkg::WB_PORTS,
    parameter  int DATA_W   = rob_pkg::DATA_W,
    parameter  int REG_AW   = rob_pkg::REG_AW,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    input  logic [DATA_W-1:0]      alloc_pc,
    input  logic [REG_AW-1:0]      alloc_reg,
    input  logic                   alloc_w,
    input  logic                   alloc_load,
    input  logic                   alloc_store,
    output logic [AW-1:0]          alloc_tag,
    input  logic [WB_PORTS-1:0]    wb_valid,
    input  logic [WB_PORTS*AW-1:0] wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0] wb_val,
    input  logic [WB_PORTS-1:0]    wb_jump,
    output logic                   c_valid,
    output logic [DATA_W-1:0]      c_pc,
    output logic [REG_AW-1:0]      c_reg,
    output logic [DATA_W-1:0]      c_val,
    output logic                   c_w,
    output logic                   c_load,
    output logic                   c_store,
    output logic                   flush,
`ifdef ROB_FWD_EN
    input  logic [REG_AW-1:0]      q_reg,
    output logic                   q_hit,
    output logic                   q_ready,
    output logic [DATA_W-1:0]      q_val,
`endif
    output logic [AW:0]            count,
    output logic                   empty,
    output logic                   full
);

    import rob_pkg::*;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    rob_entry_t        ent_q [DEPTH];
    rob_entry_t        ent_d [DEPTH];
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d, wb_idx;
    logic [AW:0]       count_q, count_d;
    logic              c_valid_q, c_valid_d, flush_q, flush_d;
    logic [DATA_W-1:0] c_pc_q, c_pc_d, c_val_q, c_val_d;
    logic [REG_AW-1:0] c_reg_q, c_reg_d;
    logic              c_w_q, c_w_d, c_load_q, c_load_d, c_store_q, c_store_d;
    logic              do_alloc, do_commit;

    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign alloc_ready = !full && !flush_q;
    assign alloc_tag   = tail_q;
    assign do_alloc    = alloc_valid && alloc_ready;
    assign do_commit   = ent_q[head_q].busy && ent_q[head_q].done;

    assign c_valid = c_valid_q;
    assign c_pc    = c_pc_q;
    assign c_reg   = c_reg_q;
    assign c_val   = c_val_q;
    assign c_w     = c_w_q;
    assign c_load  = c_load_q;
    assign c_store = c_store_q;
    assign flush   = flush_q;

    // Next-state: writebacks, head commit, tail allocate, then a jump flush overrides all.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        ent_d     = ent_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wb_idx    = '0;
        c_valid_d = 1'b0;
        flush_d   = 1'b0;
        c_pc_d    = '0;
        c_reg_d   = '0;
        c_val_d   = '0;
        c_w_d     = 1'b0;
        c_load_d  = 1'b0;
        c_store_d = 1'b0;

        // Ascending port order lets the highest-index port win a shared tag.
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_idx = wb_tag[p*AW +: AW];
            if (!flush_q && wb_valid[p] && ent_q[wb_idx].busy) begin
                ent_d[wb_idx].done = 1'b1;
                ent_d[wb_idx].val  = wb_val[p*DATA_W +: DATA_W];
                ent_d[wb_idx].jump = wb_jump[p];
            end
        end

        if (do_commit) begin
            c_valid_d = 1'b1;
            flush_d   = ent_q[head_q].jump;
            c_pc_d    = ent_q[head_q].pc;
            c_reg_d   = ent_q[head_q].dst_reg;
            c_val_d   = ent_q[head_q].val;
            c_w_d     = ent_q[head_q].w;
            c_load_d  = ent_q[head_q].load;
            c_store_d = ent_q[head_q].store;
            ent_d[head_q].busy = 1'b0;
            ent_d[head_q].done = 1'b0;
            head_d = head_q + 1'b1;
        end

        if (do_alloc) begin
            ent_d[tail_q].pc      = alloc_pc;
            ent_d[tail_q].dst_reg = alloc_reg;
            ent_d[tail_q].val     = '0;
            ent_d[tail_q].w       = alloc_w;
            ent_d[tail_q].load    = alloc_load;
            ent_d[tail_q].store   = alloc_store;
            ent_d[tail_q].jump    = 1'b0;
            ent_d[tail_q].busy    = 1'b1;
            ent_d[tail_q].done    = 1'b0;
            tail_d = tail_q + 1'b1;
        end

        case ({do_alloc, do_commit})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A committing jump squashes everything younger, including this cycle's allocate.
        if (do_commit && ent_q[head_q].jump) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].busy = 1'b0;
                ent_d[i].done = 1'b0;
                ent_d[i].jump = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // State and commit-output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: entries are flops rather than RAM, so clearing the whole array keeps every field deterministic.
            ent_q     <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            c_valid_q <= 1'b0;
            flush_q   <= 1'b0;
            c_pc_q    <= '0;
            c_reg_q   <= '0;
            c_val_q   <= '0;
            c_w_q     <= 1'b0;
            c_load_q  <= 1'b0;
            c_store_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
            ent_q     <= ent_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            c_valid_q <= c_valid_d;
            flush_q   <= flush_d;
            c_pc_q    <= c_pc_d;
            c_reg_q   <= c_reg_d;
            c_val_q   <= c_val_d;
            c_w_q     <= c_w_d;
            c_load_q  <= c_load_d;
            c_store_q <= c_store_d;
        end
    end

`ifdef ROB_FWD_EN
    rob_fwd_search #(
        .ENTRIES (DEPTH)
    ) u_fwd_search (
        .ent_i     (ent_q),
        .head_i    (head_q),
        .q_reg_i   (q_reg),
        .q_hit_o   (q_hit),
        .q_ready_o (q_ready),
        .q_val_o   (q_val)
    );
`endif

endmodule
